// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package counter_pkg;

    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-MOD up/down counter with load, wrap/saturate, sticky
// overflow and a combinational terminal count for cascading.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MOD       = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // One extra bit keeps MOD == 2**WIDTH from aliasing MOD-1 back to zero.
    localparam logic [WIDTH:0] CNT_MAX = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] CNT_RST = (WIDTH+1)'(RESET_VAL);
    localparam logic [WIDTH:0] CNT_ONE = (WIDTH+1)'(1);

    logic [WIDTH:0] count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [WIDTH:0] load_ext;
    logic           at_top, at_bot;

    assign load_ext = {1'b0, load_val};
    assign at_top   = (count_q == CNT_MAX);
    assign at_bot   = (count_q == '0);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q & ~clr_ovf;
        if (load) begin
            count_d = (load_ext > CNT_MAX) ? CNT_MAX : load_ext;
        end else if (en) begin
            if (up_dn == CNT_UP) begin
                if (at_top) begin
                    ovf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? count_q : '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end else begin
                if (at_bot) begin
                    ovf_d   = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? count_q : CNT_MAX;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_RST;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q   = count_q[WIDTH-1:0];
    assign ovf = ovf_q;
    assign tc  = en & ~load & (((up_dn == CNT_UP) & at_top) | ((up_dn == CNT_DN) & at_bot));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed plus randomized checks of mod_updown_counter against an arithmetic model.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, up_dn, load, sat_mode, clr_ovf;
    logic [3:0] load_val;
    logic [3:0] q10, q16;
    logic       tc10, tc16, ovf10, ovf16;

    logic       c_rst, c_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_ovf, hi_ovf;

    mod_updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) dut10 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
        .q(q10), .tc(tc10), .ovf(ovf10));

    mod_updown_counter #(.WIDTH(4), .MOD(16), .RESET_VAL(3)) dut16 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
        .q(q16), .tc(tc16), .ovf(ovf16));

    // Two-digit decade chain: the upper digit advances on the lower digit's tc.
    mod_updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_lo (
        .clk(clk), .reset(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .sat_mode(1'b0), .clr_ovf(1'b0),
        .q(lo_q), .tc(lo_tc), .ovf(lo_ovf));

    mod_updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_hi (
        .clk(clk), .reset(c_rst), .en(lo_tc), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .sat_mode(1'b0), .clr_ovf(1'b0),
        .q(hi_q), .tc(hi_tc), .ovf(hi_ovf));

    int vectors = 0;
    int miscompares = 0;

    int mq[2];
    bit mo[2];
    int mod_of[2] = '{10, 16};
    int rv_of[2]  = '{0, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit mtc(input int i);
        if (!en || load) return 1'b0;
        return up_dn ? (mq[i] == mod_of[i] - 1) : (mq[i] == 0);
    endfunction

    function automatic void medge(input int i);
        bit hit;
        hit = 1'b0;
        if (reset) begin
            mq[i] = rv_of[i];
            mo[i] = 1'b0;
            return;
        end
        if (load) begin
            mq[i] = (int'(load_val) < mod_of[i]) ? int'(load_val) : mod_of[i] - 1;
        end else if (en) begin
            if (up_dn) begin
                if (mq[i] == mod_of[i] - 1) begin
                    hit = 1'b1;
                    if (!sat_mode) mq[i] = 0;
                end else mq[i] = mq[i] + 1;
            end else begin
                if (mq[i] == 0) begin
                    hit = 1'b1;
                    if (!sat_mode) mq[i] = mod_of[i] - 1;
                end else mq[i] = mq[i] - 1;
            end
        end
        mo[i] = hit | (mo[i] & !clr_ovf);
    endfunction

    task automatic drive(input bit r, input bit l, input int lv, input bit e,
                         input bit u, input bit s, input bit c);
        reset = r; load = l; load_val = 4'(lv); en = e; up_dn = u; sat_mode = s; clr_ovf = c;
    endtask

    // tc is checked before the edge with the pre-edge state; q/ovf just after.
    task automatic step();
        @(negedge clk);
        chk("tc10", tc10, mtc(0));
        chk("tc16", tc16, mtc(1));
        @(posedge clk);
        medge(0);
        medge(1);
        #1;
        chk("q10", q10, mq[0]);
        chk("ovf10", ovf10, mo[0]);
        chk("q16", q16, mq[1]);
        chk("ovf16", ovf16, mo[1]);
    endtask

    initial begin
        c_rst = 1'b1; c_en = 1'b0;
        drive(1, 0, 0, 0, 1, 0, 0);
        step();
        chk("rst_q10", q10, 0);
        chk("rst_q16", q16, 3);
        chk("rst_ovf10", ovf10, 0);
        c_rst = 1'b0;

        // Up count, wrap mode: 0..9 then 0, ovf on the wrap.
        drive(0, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 10; k++) step();
        chk("wrap_q10", q10, 0);
        chk("wrap_ovf10", ovf10, 1);

        // Saturate down from 2.
        drive(0, 1, 2, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 1, 0, 1, 0);
        for (int k = 0; k < 4; k++) step();
        chk("sat_q10", q10, 0);
        chk("sat_ovf10", ovf10, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        step();
        chk("clr_ovf10", ovf10, 0);

        // Load clamp, load over en, reset over load.
        drive(0, 1, 13, 0, 1, 0, 0);
        step();
        chk("clamp_q10", q10, 9);
        chk("clamp_q16", q16, 13);
        drive(0, 1, 4, 1, 1, 0, 0);
        step();
        chk("load_en_q10", q10, 4);
        drive(1, 1, 7, 1, 1, 0, 0);
        step();
        chk("rst_load_q10", q10, 0);
        chk("rst_load_q16", q16, 3);

        // Reset mid-count, then resume.
        drive(0, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 6; k++) step();
        chk("mid_q10", q10, 6);
        drive(1, 0, 0, 1, 1, 0, 0);
        step();
        chk("mid_rst_q10", q10, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        step();
        chk("resume_q10", q10, 1);

        // Full-range modulus: 15 -> 0 up, 0 -> 15 down.
        drive(0, 1, 15, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 1, 1, 0, 0);
        step();
        chk("full_up_q16", q16, 0);
        chk("full_up_ovf16", ovf16, 1);
        drive(0, 0, 0, 1, 0, 0, 0);
        step();
        chk("full_dn_q16", q16, 15);

        // Set and clear of ovf on the same edge: set wins.
        drive(0, 1, 9, 0, 1, 0, 1);
        step();
        drive(0, 0, 0, 1, 1, 0, 1);
        step();
        chk("setclr_ovf10", ovf10, 1);
        chk("setclr_ovf16", ovf16, 0);

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0);
            step();
        end
        drive(0, 0, 0, 0, 1, 0, 0);

        // Decade cascade 00..99 then 00.
        chk("casc_lo0", lo_q, 0);
        chk("casc_hi0", hi_q, 0);
        c_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            chk("casc_lo", lo_q, (k % 100) % 10);
            chk("casc_hi", hi_q, (k % 100) / 10);
        end
        c_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised successor to the 4-bit ripple counter: synchronous modulo-N up/down counter with parallel load, count enable, wrap or saturate mode, and a sticky overflow flag.
- Provides a terminal-count output so instances can be cascaded for wider or decade counts.
- Used wherever the design needs event counting, timers or BCD digit chains.

Parameters:
WIDTH, 4, counter width in bits.
MOD, 16, count modulus; legal range 2 .. 2**WIDTH; the count sequence is 0 .. MOD-1.
RESET_VAL, 0, value loaded on reset; must be < MOD.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable.
up_dn  input  1  direction: 1 = up, 0 = down.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value to load.
sat_mode  input  1  boundary mode: 1 = saturate at the boundary, 0 = wrap modulo MOD.
clr_ovf  input  1  clears the sticky overflow flag.
q  output  WIDTH  current count, registered.
tc  output  1  terminal count, combinational; used as the cascade carry/borrow.
ovf  output  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset (reset=1 at a rising clk edge):
  - q <= RESET_VAL; ovf <= 0.
  - Overrides every other input in the same cycle.
  - Asserting reset mid-count abandons the count; no partial update.
- Priority at each edge: reset > load > en. With en=0 and load=0, q holds.
- Load:
  - q <= load_val if load_val < MOD, else q <= MOD-1 (clamp).
  - Takes effect in one cycle, regardless of en, up_dn or sat_mode.
  - Load never sets ovf.
- Count (en=1, load=0), single-cycle latency. Boundary = MOD-1 when up, 0 when down.
  - Up, q < MOD-1: q <= q+1.
  - Up, q == MOD-1, wrap mode: q <= 0 and ovf <= 1.
  - Up, q == MOD-1, saturate mode: q holds at MOD-1 and ovf <= 1.
  - Down, q > 0: q <= q-1.
  - Down, q == 0, wrap mode: q <= MOD-1 and ovf <= 1.
  - Down, q == 0, saturate mode: q holds at 0 and ovf <= 1.
- Arithmetic and state:
  - Compute next-state in WIDTH+1 bits so that MOD = 2**WIDTH does not alias.
  - q never holds a value >= MOD.
- tc:
  - tc = en & ~load & ((up_dn & q==MOD-1) | (~up_dn & q==0)).
  - Combinational, same cycle; 0 during reset is not required because reset is synchronous.
  - In a cascade, the upper stage's en is driven from the lower stage's tc.
- ovf:
  - Set on any wrap or saturate boundary event; cleared by clr_ovf.
  - Simultaneous set and clear in the same cycle: set wins, so ovf = 1.
- Direction change (up_dn toggling mid-count) takes effect on the next enabled edge, with no dead cycle.
- All outputs are free of X after the first reset edge.

Decomposition:
- Shared package counter_pkg:
  - Constants CNT_UP = 1'b1, CNT_DN = 1'b0, MODE_WRAP = 1'b0, MODE_SAT = 1'b1.
  - Function clog2 for derived widths.
- No sub-module; the block is a single flat module.
- A decade chain is built at the instantiating level from multiple instances.

Test Plan:
- WIDTH=4, MOD=10, wrap mode, up, en=1 after reset:
  - q steps 0..9, then 0.
  - tc=1 only while q=9.
  - ovf rises on the edge of the 9->0 transition and stays 1.
- MOD=10, saturate mode, down, load_val=2 then en=1:
  - q = 2, 1, 0, 0, 0.
  - tc=1 while q=0; ovf=1 after the first held edge.
  - Pulse clr_ovf with en=0 -> ovf=0.
- Load clamp and priority:
  - load=1, load_val=13, MOD=10 -> q=9.
  - load and en asserted together -> the load value wins.
  - reset and load asserted together -> q=RESET_VAL.
- Mid-operation reset with RESET_VAL=0:
  - Count to q=6, assert reset for 1 cycle -> q=0 and ovf=0 on that edge.
  - Counting resumes from 0 on the next edge.
- MOD=16 (full range), wrap mode:
  - Up: q=15 -> 0 with ovf=1.
  - Down: q=0 -> 15.
  - Confirms no aliasing in the WIDTH+1 arithmetic.
- Simultaneous ovf set/clear and cascade:
  - clr_ovf=1 on the same edge as a wrap -> ovf=1.
  - Two MOD=10 instances, upper en driven from lower tc, count 0..99 -> {upper,lower} reads 9,9 then 0,0.
